// File: rtl/l2_miss_arbiter.sv
// l2_miss_arbiter
//   Shares the single L2 port between the icache miss path (read only) and the
//   data-side miss path (read or writeback). A winning request is latched into
//   registered L2-side outputs and held until l2_resp. The line is then handed
//   back with a one-cycle resp pulse. One release state (DONE) follows, so the
//   requester can drop its request before the next arbitration.
//
// Optional feature (macro ARB_ROUND_ROBIN_EN):
//   defined   - simultaneous requests go to the side named by a priority
//               pointer. After every grant the pointer names the side that was
//               not granted. It resets to D.
//   undefined - D always wins simultaneous requests. No pointer is built.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_read/i_addr         icache miss request (held until i_resp)
//   i_rdata/i_resp        returned line and completion pulse to icache
//   d_read/d_write/d_addr data-side miss read / writeback (held until d_resp)
//   d_wdata               writeback line
//   d_rdata/d_resp        returned line and completion pulse to data side
//   l2_read/l2_write      registered request to L2 (never both high)
//   l2_addr/l2_wdata      registered line-aligned address and write line
//   l2_rdata/l2_resp      L2 read data and completion pulse
//   busy                  high whenever the arbiter is not IDLE
module l2_miss_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int LINE_W      = 256,
    parameter int OFFSET_BITS = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Clears the offset bits so that the L2 always sees a line-aligned address.
    localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFFSET_BITS;

    state_t state;
    logic   d_req;
    logic   grant_d;
    logic   grant_i;

    assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = D has priority on the next simultaneous request.
    logic prio_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_d <= 1'b1;
        end else if (state == IDLE && (grant_d || grant_i)) begin
            prio_d <= grant_i;
        end
    end

    assign grant_d = d_req & (~i_read | prio_d);
`else
    assign grant_d = d_req;
`endif

    assign grant_i = i_read & ~grant_d;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            l2_read  <= 1'b0;
            l2_write <= 1'b0;
            l2_addr  <= '0;
            l2_wdata <= '0;
            i_rdata  <= '0;
            d_rdata  <= '0;
            i_resp   <= 1'b0;
            d_resp   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // l2_resp arriving here belongs to nobody and is dropped.
                    if (grant_d) begin
                        l2_addr  <= d_addr & LINE_MASK;
                        l2_wdata <= d_wdata;
                        // An illegal read+write request is treated as a write.
                        l2_write <= d_write;
                        l2_read  <= ~d_write;
                        state    <= D_BUSY;
                    end else if (grant_i) begin
                        l2_addr  <= i_addr & LINE_MASK;
                        l2_read  <= 1'b1;
                        l2_write <= 1'b0;
                        state    <= I_BUSY;
                    end
                end
                I_BUSY: begin
                    if (l2_resp) begin
                        l2_read <= 1'b0;
                        i_rdata <= l2_rdata;
                        i_resp  <= 1'b1;
                        state   <= DONE;
                    end
                end
                D_BUSY: begin
                    if (l2_resp) begin
                        // A writeback returns no data; d_rdata keeps the old line.
                        if (!l2_write) begin
                            d_rdata <= l2_rdata;
                        end
                        l2_read  <= 1'b0;
                        l2_write <= 1'b0;
                        d_resp   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    i_resp <= 1'b0;
                    d_resp <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
